// File: rtl/decode_pkg.sv
// decode_pkg: shared MIPS decode constants, ctrl/exc bit indices and the
// queue entry payload used by decode_queue and decq_ctrl_dec.
package decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CTRL_W  = 14;
  localparam int unsigned EXC_W   = 6;

  // out_ctrl bit positions
  localparam int unsigned CTRL_REGWRITE  = 13;
  localparam int unsigned CTRL_REGDST    = 12;
  localparam int unsigned CTRL_ALUSRC    = 11;
  localparam int unsigned CTRL_BRANCH    = 10;
  localparam int unsigned CTRL_MEMWRITE  = 9;
  localparam int unsigned CTRL_MEMTOREG  = 8;
  localparam int unsigned CTRL_JUMP      = 7;
  localparam int unsigned CTRL_JALR      = 6;
  localparam int unsigned CTRL_SIGN_EXT  = 5;
  localparam int unsigned CTRL_HILODST   = 4;
  localparam int unsigned CTRL_HILOWRITE = 3;
  localparam int unsigned CTRL_HILOREAD  = 2;
  localparam int unsigned CTRL_MEMREAD   = 1;
  localparam int unsigned CTRL_RAWRITE   = 0;

  // out_exc bit positions
  localparam int unsigned EXC_INVALID = 5;
  localparam int unsigned EXC_SYSCALL = 4;
  localparam int unsigned EXC_BREAK   = 3;
  localparam int unsigned EXC_ERET    = 2;
  localparam int unsigned EXC_CP0WE   = 1;
  localparam int unsigned EXC_CP0READ = 0;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;
  localparam logic [5:0] FN_ERET    = 6'b011000;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // COP0 rs codes
  localparam logic [4:0] RS_MFC0 = 5'b00000;
  localparam logic [4:0] RS_MTC0 = 5'b00100;
  localparam logic [4:0] RS_CO   = 5'b10000;

  // One queue slot (PC is held separately since its width is a parameter)
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
    logic [EXC_W-1:0]   exc;
    logic               is_ds;
  } decq_entry_t;

  // Entry opens a branch delay slot
  function automatic logic is_xfer(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_BRANCH] | ctrl[CTRL_JUMP] | ctrl[CTRL_JALR];
  endfunction

endpackage

// File: rtl/decq_ctrl_dec.sv
// decq_ctrl_dec: combinational MIPS main decoder, instr -> {ctrl, exc}.
// Ports: instr (32) in; ctrl_c (14) out; exc_c (6) out.
// Any unknown opcode, funct, REGIMM rt or COP0 form raises exc invalid with
// ctrl and the remaining exc bits forced to zero.
module decq_ctrl_dec
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [CTRL_W-1:0]  ctrl_c,
  output logic [EXC_W-1:0]   exc_c
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       invalid;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];

  always_comb begin
    ctrl_c  = '0;
    exc_c   = '0;
    invalid = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLT, FN_SLTU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            ctrl_c[CTRL_REGWRITE] = 1'b1;
            ctrl_c[CTRL_REGDST]   = 1'b1;
          end
          FN_JR: ctrl_c[CTRL_JALR] = 1'b1;
          FN_JALR: begin
            ctrl_c[CTRL_JALR]     = 1'b1;
            ctrl_c[CTRL_REGWRITE] = 1'b1;
            ctrl_c[CTRL_REGDST]   = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: ctrl_c[CTRL_HILOWRITE] = 1'b1;
          FN_MFHI, FN_MFLO: begin
            ctrl_c[CTRL_REGWRITE] = 1'b1;
            ctrl_c[CTRL_REGDST]   = 1'b1;
            ctrl_c[CTRL_HILOREAD] = 1'b1;
            ctrl_c[CTRL_HILODST]  = (funct == FN_MFHI);
          end
          FN_MTHI, FN_MTLO: begin
            ctrl_c[CTRL_HILOWRITE] = 1'b1;
            ctrl_c[CTRL_HILODST]   = (funct == FN_MTHI);
          end
          FN_SYSCALL: exc_c[EXC_SYSCALL] = 1'b1;
          FN_BREAK:   exc_c[EXC_BREAK]   = 1'b1;
          default:    invalid = 1'b1;
        endcase
      end
      // rt[4] selects the linking forms BLTZAL/BGEZAL
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL) begin
          ctrl_c[CTRL_BRANCH]   = 1'b1;
          ctrl_c[CTRL_SIGN_EXT] = 1'b1;
          ctrl_c[CTRL_REGWRITE] = rt[4];
          ctrl_c[CTRL_JALR]     = rt[4];
          ctrl_c[CTRL_RAWRITE]  = rt[4];
        end else begin
          invalid = 1'b1;
        end
      end
      OP_J: ctrl_c[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl_c[CTRL_JUMP]     = 1'b1;
        ctrl_c[CTRL_REGWRITE] = 1'b1;
        ctrl_c[CTRL_RAWRITE]  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl_c[CTRL_BRANCH]   = 1'b1;
        ctrl_c[CTRL_SIGN_EXT] = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl_c[CTRL_REGWRITE] = 1'b1;
        ctrl_c[CTRL_ALUSRC]   = 1'b1;
        ctrl_c[CTRL_SIGN_EXT] = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_c[CTRL_REGWRITE] = 1'b1;
        ctrl_c[CTRL_ALUSRC]   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl_c[CTRL_REGWRITE] = 1'b1;
        ctrl_c[CTRL_ALUSRC]   = 1'b1;
        ctrl_c[CTRL_SIGN_EXT] = 1'b1;
        ctrl_c[CTRL_MEMTOREG] = 1'b1;
        ctrl_c[CTRL_MEMREAD]  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl_c[CTRL_ALUSRC]   = 1'b1;
        ctrl_c[CTRL_SIGN_EXT] = 1'b1;
        ctrl_c[CTRL_MEMWRITE] = 1'b1;
      end
      // ERET is only accepted in its exact canonical encoding
      OP_COP0: begin
        if (rs == RS_MFC0) begin
          ctrl_c[CTRL_REGWRITE] = 1'b1;
          exc_c[EXC_CP0READ]    = 1'b1;
        end else if (rs == RS_MTC0) begin
          exc_c[EXC_CP0WE] = 1'b1;
        end else if (rs == RS_CO && funct == FN_ERET && instr[20:6] == 15'd0) begin
          exc_c[EXC_ERET] = 1'b1;
        end else begin
          invalid = 1'b1;
        end
      end
      default: invalid = 1'b1;
    endcase

    if (invalid) begin
      ctrl_c             = '0;
      exc_c              = '0;
      exc_c[EXC_INVALID] = 1'b1;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO between fetch and ID/EX that
// decodes each instruction once on entry and tags branch delay slots.
// Ports: clk, resetn (sync, active-low), flush;
//   in_valid/in_ready/in_instr/in_pc    - fetch side push handshake;
//   out_valid/out_ready/out_pc/out_instr/out_ctrl/out_exc/out_is_ds - head;
//   count - occupancy.
// Optional macro DECQ_PERF_EN adds perf_full_cyc / perf_empty_cyc (32-bit
// saturating cycle counters, cleared only by resetn).
module decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [13:0]                out_ctrl,
  output logic [5:0]                 out_exc,
  output logic                       out_is_ds,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DECQ_PERF_EN
  ,
  output logic [31:0]                perf_full_cyc,
  output logic [31:0]                perf_empty_cyc
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ds_pending_q, ds_pending_d;

  decq_entry_t      mem_q [DEPTH];
  logic [PC_W-1:0]  pc_q  [DEPTH];

  logic             push, pop, wr_en;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [EXC_W-1:0]  dec_exc;
  decq_entry_t      new_entry;
  decq_entry_t      head;

  // Handshake flags depend only on registered occupancy
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  decq_ctrl_dec u_dec (
    .instr  (in_instr),
    .ctrl_c (dec_ctrl),
    .exc_c  (dec_exc)
  );

  always_comb begin
    new_entry.instr = in_instr;
    new_entry.ctrl  = dec_ctrl;
    new_entry.exc   = dec_exc;
    new_entry.is_ds = ds_pending_q;
  end

  // Pointer/occupancy/delay-slot next state; flush overrides push and pop
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ds_pending_d = ds_pending_q;
    wr_en        = 1'b0;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      ds_pending_d = 1'b0;
    end else begin
      if (push) begin
        wr_en        = 1'b1;
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        ds_pending_d = is_xfer(dec_ctrl);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ds_pending_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ds_pending_q <= ds_pending_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= new_entry;
      pc_q[wr_ptr_q]  <= in_pc;
    end
  end

  // Head mux, zeroed when empty
  always_comb begin
    head = '0;
    out_pc = '0;
    if (out_valid) begin
      head   = mem_q[rd_ptr_q];
      out_pc = pc_q[rd_ptr_q];
    end
  end

  assign out_instr = head.instr;
  assign out_ctrl  = head.ctrl;
  assign out_exc   = head.exc;
  assign out_is_ds = head.is_ds;

`ifdef DECQ_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  // Saturating occupancy counters, independent of flush
  always_comb begin
    perf_full_d  = perf_full_q;
    perf_empty_d = perf_empty_q;
    if (count_q == CNT_W'(DEPTH) && perf_full_q != '1) begin
      perf_full_d = perf_full_q + 32'd1;
    end
    if (count_q == '0 && perf_empty_q != '1) begin
      perf_empty_d = perf_empty_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_full_q  <= perf_full_d;
      perf_empty_q <= perf_empty_d;
    end
  end

  assign perf_full_cyc  = perf_full_q;
  assign perf_empty_cyc = perf_empty_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue (DEPTH=4).
module tb_decode_queue;

  localparam logic [31:0] I_ADDIU   = 32'h24010005;
  localparam logic [31:0] I_BEQ     = 32'h10000003;
  localparam logic [31:0] I_BNE     = 32'h14000002;
  localparam logic [31:0] I_ADDU    = 32'h00221821;
  localparam logic [31:0] I_NOP     = 32'h00000000;
  localparam logic [31:0] I_BADOP   = 32'hFC000000;
  localparam logic [31:0] I_SYSCALL = 32'h0000000C;
  localparam logic [31:0] I_BADCP0  = 32'h40200000;
  localparam logic [31:0] I_BADFN   = 32'h00000001;
  localparam logic [31:0] I_MFC0    = 32'h40016000;
  localparam logic [31:0] I_ERET    = 32'h42000018;
  localparam logic [31:0] I_BGEZAL  = 32'h04110001;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_is_ds;
  logic [31:0] in_instr, in_pc, out_pc, out_instr;
  logic [13:0] out_ctrl;
  logic [5:0]  out_exc;
  logic [2:0]  count;
`ifdef DECQ_PERF_EN
  logic [31:0] perf_full_cyc, perf_empty_cyc;
  logic [31:0] snap;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ctrl  (out_ctrl),
    .out_exc   (out_exc),
    .out_is_ds (out_is_ds),
    .count     (count)
`ifdef DECQ_PERF_EN
    ,
    .perf_full_cyc  (perf_full_cyc),
    .perf_empty_cyc (perf_empty_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    cyc(); cyc();
    resetn = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);

    // ADDIU: regwrite|alusrc|sign_ext
    push1(I_ADDIU, 32'hBFC00000);
    chk("addiu_valid", 32'(out_valid), 32'd1);
    chk("addiu_ctrl",  32'(out_ctrl),  32'h2820);
    chk("addiu_exc",   32'(out_exc),   32'd0);
    chk("addiu_ds",    32'(out_is_ds), 32'd0);
    chk("addiu_count", 32'(count),     32'd1);
    chk("addiu_pc",    out_pc,         32'hBFC00000);
    chk("addiu_instr", out_instr,      I_ADDIU);
    pop1();
    chk("addiu_popped", 32'(count), 32'd0);

    // Delay-slot tracking
    push1(I_BEQ,  32'h100);
    push1(I_ADDU, 32'h104);
    chk("beq_branch", 32'(out_ctrl[10]), 32'd1);
    chk("beq_ds",     32'(out_is_ds),    32'd0);
    pop1();
    chk("addu_pc",   out_pc,          32'h104);
    chk("addu_ds",   32'(out_is_ds),  32'd1);
    chk("addu_ctrl", 32'(out_ctrl),   32'h3000);
    pop1();
    push1(I_ADDU, 32'h108);
    chk("addu2_ds", 32'(out_is_ds), 32'd0);
    pop1();
    // offset pointers so the fill below wraps
    push1(I_NOP, 32'h10C);
    pop1();

    // Fill to DEPTH with out_ready low
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h200 + 32'(4*i);
      cyc();
    end
    chk("full_count", 32'(count),    32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h210;
    cyc();
    in_valid = 1'b0;
    chk("full_ignored", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'h200 + 32'(4*i));
      cyc();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count=2
    push1(I_ADDU, 32'h300);
    push1(I_ADDU, 32'h304);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h308 + 32'(4*k);
      out_ready = 1'b1;
      chk("pp_pc", out_pc, 32'h300 + 32'(4*k));
      cyc();
      chk("pp_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", out_pc, 32'h328);
    cyc();
    chk("pp_tail1", out_pc, 32'h32C);
    cyc();
    out_ready = 1'b0;
    chk("pp_empty", 32'(count), 32'd0);

    // Flush beats a concurrent push and pop, and clears delay-slot state
    push1(I_BNE, 32'h400);
    in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h404;
    out_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    push1(I_ADDU, 32'h408);
    chk("flush_next_pc", out_pc,         32'h408);
    chk("flush_next_ds", 32'(out_is_ds), 32'd0);
    pop1();

    // Invalid detection and exception flags
    push1(I_BADOP,   32'h500);
    push1(I_SYSCALL, 32'h504);
    push1(I_BADCP0,  32'h508);
    push1(I_BADFN,   32'h50C);
    chk("badop_exc",  32'(out_exc),  32'h20);
    chk("badop_ctrl", 32'(out_ctrl), 32'd0);
    pop1();
    chk("sys_exc",  32'(out_exc),  32'h10);
    chk("sys_ctrl", 32'(out_ctrl), 32'd0);
    pop1();
    chk("badcp0_exc", 32'(out_exc), 32'h20);
    pop1();
    chk("badfn_exc",  32'(out_exc),  32'h20);
    chk("badfn_ctrl", 32'(out_ctrl), 32'd0);
    pop1();

    push1(I_MFC0,   32'h600);
    push1(I_ERET,   32'h604);
    push1(I_BGEZAL, 32'h608);
    push1(I_ADDU,   32'h60C);
    chk("mfc0_exc", 32'(out_exc), 32'h01);
    pop1();
    chk("eret_exc", 32'(out_exc), 32'h04);
    pop1();
    chk("bgezal_rawrite", 32'(out_ctrl[0]), 32'd1);
    chk("bgezal_exc",     32'(out_exc),     32'd0);
    pop1();
    chk("after_bgezal_ds", 32'(out_is_ds), 32'd1);
    pop1();

`ifdef DECQ_PERF_EN
    snap = perf_empty_cyc;
    cyc(); cyc(); cyc();
    chk("perf_empty_idle", perf_empty_cyc, snap + 32'd3);
    snap = perf_empty_cyc;
    push1(I_ADDU, 32'h700);
    cyc(); cyc(); cyc();
    chk("perf_empty_busy", perf_empty_cyc, snap + 32'd1);
    pop1();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
